// File: rtl/tape_store.sv
// tape_store: tape RAM, head pointer and host preload/dump port beside utm_core.
// Optional feature macro: TAPE_EDGE_TRAP_EN. When it is defined, a head move past
// either tape end traps into FAULT and raises edge_fault instead of wrapping.
//
// state   | meaning
// CLEAR   | zero one tape cell per cycle after reset
// IDLE    | waiting for a host command; preload writes land here
// FETCH   | read the head cell into sym
// PRESENT | sym_valid high; commit new_sym and move the head on this edge
// DUMP    | stream every tape cell to the host with valid/ready
// FAULT   | head tried to leave the tape (edge trap build only)
module tape_store #(
  parameter int ADDR_W    = 5,
  parameter int SYM_W     = 3,
  parameter int START_POS = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              direction,
  input  logic [SYM_W-1:0]  new_sym,
  output logic [SYM_W-1:0]  sym,
  output logic              sym_valid,
  input  logic              start,
  input  logic              stop,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [SYM_W-1:0]  load_data,
  input  logic              dump_req,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [SYM_W-1:0]  dump_data,
  output logic              busy,
  output logic [ADDR_W-1:0] head_pos
`ifdef TAPE_EDGE_TRAP_EN
  ,
  output logic              edge_fault
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_POS);
  localparam logic [ADDR_W-1:0] LAST_A  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_FETCH,
    ST_PRESENT,
    ST_DUMP,
    ST_FAULT
  } state_t;

  state_t state, state_nxt;

  logic [SYM_W-1:0]  ram [DEPTH];
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] dump_addr_inc;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [SYM_W-1:0]  ram_wdata;

  assign dump_addr_inc = dump_addr + ONE_A;
  assign sym_valid     = (state == ST_PRESENT);
  assign busy          = (state != ST_IDLE);

`ifdef TAPE_EDGE_TRAP_EN
  logic at_edge;
  assign at_edge    = direction ? (head_pos == LAST_A) : (head_pos == '0);
  assign edge_fault = (state == ST_FAULT);
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_CLEAR;
    else       state <= state_nxt;
  end

  // Next-state decode and the single RAM write port mux
  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_addr  = head_pos;
    ram_wdata = new_sym;
    case (state)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_addr;
        ram_wdata = '0;
        if (clr_addr == LAST_A) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_FETCH;
        end else if (dump_req) begin
          state_nxt = ST_DUMP;
        end else if (load_en) begin
          ram_we    = 1'b1;
          ram_addr  = load_addr;
          ram_wdata = load_data;
        end
      end
      ST_FETCH: state_nxt = stop ? ST_IDLE : ST_PRESENT;
      ST_PRESENT: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else begin
          ram_we    = 1'b1;
          state_nxt = ST_FETCH;
`ifdef TAPE_EDGE_TRAP_EN
          if (at_edge) state_nxt = ST_FAULT;
`endif
        end
      end
      ST_DUMP: begin
        if (stop) state_nxt = ST_IDLE;
        else if (dump_valid && dump_ready && dump_addr == LAST_A) state_nxt = ST_IDLE;
      end
`ifdef TAPE_EDGE_TRAP_EN
      ST_FAULT: if (stop) state_nxt = ST_IDLE;
`endif
      default: state_nxt = ST_CLEAR;
    endcase
  end

  // Tape RAM write; contents are rebuilt by CLEAR so no reset is needed here
  always_ff @(posedge clock) begin
    if (ram_we && !reset) ram[ram_addr] <= ram_wdata;
  end

  // Head pointer, presented symbol, clear counter and dump beat registers
  always_ff @(posedge clock) begin
    if (reset) begin
      clr_addr   <= '0;
      head_pos   <= START_A;
      sym        <= '0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      case (state)
        ST_CLEAR: clr_addr <= clr_addr + ONE_A;
        ST_IDLE: begin
          if (start) begin
            head_pos <= START_A;
          end else if (dump_req) begin
            dump_addr  <= '0;
            dump_valid <= 1'b0;
          end
        end
        ST_FETCH: if (!stop) sym <= ram[head_pos];
        ST_PRESENT: begin
          if (!stop) begin
`ifdef TAPE_EDGE_TRAP_EN
            if (!at_edge)
              head_pos <= direction ? head_pos + ONE_A : head_pos - ONE_A;
`else
            head_pos <= direction ? head_pos + ONE_A : head_pos - ONE_A;
`endif
          end
        end
        ST_DUMP: begin
          if (stop) begin
            dump_valid <= 1'b0;
          end else if (!dump_valid) begin
            dump_data  <= ram[dump_addr];
            dump_valid <= 1'b1;
          end else if (dump_ready) begin
            if (dump_addr == LAST_A) begin
              dump_valid <= 1'b0;
            end else begin
              dump_addr <= dump_addr_inc;
              dump_data <= ram[dump_addr_inc];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
